// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-return engine.
// Accepts a change amount in IDLE and pays it out one coin at a time through a
// req/ack handshake with the coin hopper. The largest coin that fits the
// remaining amount and is still in stock is always picked. Per-denomination
// stock is tracked internally and can be reloaded while IDLE.
// Coin codes: 00=5, 01=10, 10=20, 11=50.
//
// Optional feature macro: CHG_ACK_TIMEOUT_EN
//   defined   -> a hopper that does not ack within TIMEOUT_CYCLES marks that
//                denomination as jammed (stock forced to 0), sets the sticky
//                jam_fault flag and payout continues with smaller coins.
//   undefined -> REQ waits for ack indefinitely, jam_fault is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   change_valid/_amount/_ready   change request handshake
//   coin_req/_sel/_ack  hopper handshake (one coin per ack)
//   stock_load/_sel/_count        stock reload (IDLE only)
//   busy, done, short_change, remaining, jam_fault  status
module change_dispenser #(
  parameter int AMT_W          = 8,
  parameter int STOCK_W        = 8,
  parameter int STOCK_INIT     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change_valid,
  input  logic [AMT_W-1:0]   change_amount,
  output logic               change_ready,
  output logic               coin_req,
  output logic [1:0]         coin_sel,
  input  logic               coin_ack,
  input  logic               stock_load,
  input  logic [1:0]         stock_sel,
  input  logic [STOCK_W-1:0] stock_count,
  output logic               busy,
  output logic               done,
  output logic               short_change,
  output logic [AMT_W-1:0]   remaining,
  output logic               jam_fault
);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic               short_q, short_d;
  logic [1:0]         sel_q, sel_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];
  logic               found;
  logic [1:0]         pick;

  function automatic logic [AMT_W-1:0] dval(input logic [1:0] c);
    case (c)
      2'b00:   dval = AMT_W'(5);
      2'b01:   dval = AMT_W'(10);
      2'b10:   dval = AMT_W'(20);
      default: dval = AMT_W'(50);
    endcase
  endfunction

  // Codes are ordered by value, so the last match in an ascending scan is the
  // largest coin that fits and is in stock.
  always_comb begin
    found = 1'b0;
    pick  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (stock_q[i] != '0 && dval(2'(i)) <= rem_q) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

`ifdef CHG_ACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             jam_q, jam_d;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    sel_d       = sel_q;
    stock_d     = stock_q;
`ifdef CHG_ACK_TIMEOUT_EN
    tmr_d       = tmr_q;
    jam_d       = jam_q;
`endif
    case (state_q)
      IDLE: begin
        // A reload on the accept edge is visible to the first SELECT.
        if (stock_load) stock_d[stock_sel] = stock_count;
        if (change_valid) begin
          rem_d       = change_amount;
          remaining_d = '0;
          short_d     = 1'b0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          sel_d   = pick;
          state_d = REQ;
`ifdef CHG_ACK_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end else begin
          remaining_d = rem_q;
          short_d     = (rem_q != '0);
          state_d     = DONE;
        end
      end
      REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (coin_ack) begin
          if (dval(sel_q) <= rem_q) rem_d = rem_q - dval(sel_q);
          if (stock_q[sel_q] != '0) stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
          state_d = SELECT;
        end
`ifdef CHG_ACK_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          stock_d[sel_q] = '0;
          jam_d          = 1'b1;
          state_d        = SELECT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      remaining_q <= '0;
      short_q     <= 1'b0;
      sel_q       <= 2'b00;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
`ifdef CHG_ACK_TIMEOUT_EN
      tmr_q       <= '0;
      jam_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      sel_q       <= sel_d;
      for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
`ifdef CHG_ACK_TIMEOUT_EN
      tmr_q       <= tmr_d;
      jam_q       <= jam_d;
`endif
    end
  end

  assign change_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign coin_req     = (state_q == REQ);
  assign coin_sel     = sel_q;
  assign done         = (state_q == DONE);
  assign short_change = short_q;
  assign remaining    = remaining_q;
`ifdef CHG_ACK_TIMEOUT_EN
  assign jam_fault    = jam_q;
`else
  assign jam_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int AMT_W = 8, STOCK_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               change_valid = 1'b0;
  logic [AMT_W-1:0]   change_amount = '0;
  logic               change_ready;
  logic               coin_req;
  logic [1:0]         coin_sel;
  logic               coin_ack = 1'b0;
  logic               stock_load = 1'b0;
  logic [1:0]         stock_sel = 2'b00;
  logic [STOCK_W-1:0] stock_count = '0;
  logic               busy, done, short_change, jam_fault;
  logic [AMT_W-1:0]   remaining;

  change_dispenser #(.AMT_W(AMT_W), .STOCK_W(STOCK_W), .STOCK_INIT(10), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .change_valid(change_valid), .change_amount(change_amount),
    .change_ready(change_ready), .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .stock_load(stock_load), .stock_sel(stock_sel), .stock_count(stock_count),
    .busy(busy), .done(done), .short_change(short_change), .remaining(remaining),
    .jam_fault(jam_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sc; logic [AMT_W-1:0] rem; } done_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_coin_q[$];
  done_t      exp_done_q[$];
  bit         ack_en = 1'b1;
  bit         hold50 = 1'b0;
  logic       prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Hopper model: acks in the first REQ cycle unless withheld.
  initial forever begin
    @(negedge clk);
    coin_ack = coin_req && ack_en && !(hold50 && coin_sel == 2'b11);
  end

  // Monitor: every new coin request and every done pulse is checked against
  // the head of its expectation queue.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (coin_req && !prev_req) begin
        if (exp_coin_q.size() == 0) flag("unexpected_coin_req");
        else chk("coin_sel", 32'(coin_sel), 32'(exp_coin_q.pop_front()));
      end
      if (done) begin
        if (exp_done_q.size() == 0) flag("unexpected_done");
        else begin
          done_t e;
          e = exp_done_q.pop_front();
          chk("short_change", 32'(short_change), 32'(e.sc));
          chk("remaining", 32'(remaining), 32'(e.rem));
        end
      end
    end
    prev_req = coin_req;
  end

  task automatic send(input logic [AMT_W-1:0] amt);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = amt;
    @(posedge clk);
    #1;
    change_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] s, input logic [STOCK_W-1:0] v);
    @(negedge clk);
    stock_load  = 1'b1;
    stock_sel   = s;
    stock_count = v;
    @(posedge clk);
    #1;
    stock_load = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag("done_timeout");
  endtask

  task automatic wait_req();
    int n = 0;
    while (!coin_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(coin_req), 32'd1);
  endtask

  task automatic chk_stocks(input string name, input int v);
    for (int i = 0; i < 4; i++) chk(name, 32'(dut.stock_q[i]), 32'(v));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(change_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(coin_req), 32'd0);
    chk("rst_sel", 32'(coin_sel), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_short", 32'(short_change), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_jam", 32'(jam_fault), 32'd0);
    chk_stocks("rst_stock", 10);
    rst = 1'b1;

    // 85 = 50+20+10+5
    exp_coin_q.push_back(2'b11); exp_coin_q.push_back(2'b10);
    exp_coin_q.push_back(2'b01); exp_coin_q.push_back(2'b00);
    exp_done_q.push_back('{sc: 1'b0, rem: 8'd0});
    send(8'd85);
    chk("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_select_no_req", 32'(coin_req), 32'd0);
    @(negedge clk);
    chk("lat_req", 32'(coin_req), 32'd1);
    wait_done();
    chk_stocks("stock_after_85", 9);

    // Amount 0: no coin, done two edges after accept
    exp_done_q.push_back('{sc: 1'b0, rem: 8'd0});
    send(8'd0);
    @(negedge clk);
    chk("zero_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("zero_done_lat", 32'(done), 32'd1);
    wait_done();

    // No 20s: 40 paid as four 10s
    load(2'b10, 8'd0);
    repeat (4) exp_coin_q.push_back(2'b01);
    exp_done_q.push_back('{sc: 1'b0, rem: 8'd0});
    send(8'd40);
    wait_done();

    // Only one 5 left: 15 -> one 5, 10 unpaid
    load(2'b11, 8'd0); load(2'b10, 8'd0); load(2'b01, 8'd0); load(2'b00, 8'd1);
    exp_coin_q.push_back(2'b00);
    exp_done_q.push_back('{sc: 1'b1, rem: 8'd10});
    send(8'd15);
    wait_done();
    chk("stock5_empty", 32'(dut.stock_q[0]), 32'd0);

    // Full stock, 7 -> one 5, residue 2
    for (int i = 0; i < 4; i++) load(2'(i), 8'd10);
    exp_coin_q.push_back(2'b00);
    exp_done_q.push_back('{sc: 1'b1, rem: 8'd2});
    send(8'd7);
    wait_done();
    @(negedge clk);
    chk("remaining_held", 32'(remaining), 32'd2);

    // Reset while a coin is requested
    ack_en = 1'b0;
    exp_coin_q.push_back(2'b11);
    load(2'b11, 8'd3);
    send(8'd50);
    wait_req();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req", 32'(coin_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(change_ready), 32'd1);
    chk_stocks("midrst_stock", 10);
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end

`ifdef CHG_ACK_TIMEOUT_EN
    // Jammed 50: timeout after 16 REQ cycles, then 10+10... wait 50-0 -> 20,20,10
    hold50 = 1'b1;
    exp_coin_q.push_back(2'b11);
    exp_coin_q.push_back(2'b10); exp_coin_q.push_back(2'b10); exp_coin_q.push_back(2'b01);
    exp_done_q.push_back('{sc: 1'b0, rem: 8'd0});
    send(8'd50);
    wait_req();
    begin
      int n = 0;
      while (coin_req && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_req_cycles", 32'(n), 32'd16);
    end
    chk("timeout_req_dropped", 32'(coin_req), 32'd0);
    chk("timeout_jam", 32'(jam_fault), 32'd1);
    chk("timeout_stock50", 32'(dut.stock_q[3]), 32'd0);
    hold50 = 1'b0;
    wait_done();
    @(negedge clk);
    chk("jam_sticky", 32'(jam_fault), 32'd1);
`else
    chk("jam_tied_low", 32'(jam_fault), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("coin_queue_drained", 32'(exp_coin_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
